// File: rtl/acc_quantizer_reader.sv
// Accumulator read-out: rounds, rescales, optionally ReLU-clamps and saturates
// each accepted accumulator to a signed DW-bit activation, buffered in a small FIFO.
module acc_quantizer_reader #(
  parameter int DW    = 8,
  parameter int AW    = 21,
  parameter int SHIFT = 7,
  parameter int DEPTH = 4,
  parameter int RELU  = 1,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic [AW-1:0] i_in_acc,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [DW-1:0] o_out_data,
  output logic [CW-1:0] o_count,
  output logic          o_sat_flag,
  input  logic          i_clr_sat
);

  localparam int PW = $clog2(DEPTH);
  localparam logic signed [AW:0] RND  = (AW+1)'(1) << (SHIFT-1);
  localparam logic signed [AW:0] MAXV = (AW+1)'((1 << (DW-1)) - 1);
  localparam logic signed [AW:0] MINV = ~MAXV;

  logic [AW-1:0]           r_s_acc;
  logic                    r_s_valid;
  logic [DEPTH-1:0][DW-1:0] r_mem;
  logic [PW-1:0]           r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]           r_count;
  logic                    r_sat;

  logic                    w_acc, w_push, w_pop;
  logic [CW:0]             w_occ;
  logic signed [AW:0]      w_sum, w_r;
  logic [DW-1:0]           w_q;
  logic                    w_sat;

  // Occupancy includes the stage value so a quantized result always has a slot.
  assign w_occ       = {1'b0, r_count} + {{CW{1'b0}}, r_s_valid};
  assign o_in_ready  = (w_occ < (CW+1)'(DEPTH));
  assign o_out_valid = (r_count != '0);
  assign o_out_data  = r_mem[r_rd_ptr];
  assign o_count     = r_count;
  assign o_sat_flag  = r_sat;

  assign w_acc  = i_in_valid && o_in_ready;
  assign w_push = r_s_valid;
  assign w_pop  = o_out_valid && i_out_ready;

  assign w_sum = $signed({r_s_acc[AW-1], r_s_acc}) + RND;
  assign w_r   = w_sum >>> SHIFT;

  always_comb begin
    w_q   = w_r[DW-1:0];
    w_sat = 1'b0;
    if ((RELU != 0) && w_r[AW]) begin
      w_q = '0;
    end else if (w_r > MAXV) begin
      w_q   = {1'b0, {(DW-1){1'b1}}};
      w_sat = 1'b1;
    end else if (w_r < MINV) begin
      w_q   = {1'b1, {(DW-1){1'b0}}};
      w_sat = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s_acc   <= '0;
      r_s_valid <= 1'b0;
      r_mem     <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_sat     <= 1'b0;
    end else begin
      r_s_valid <= w_acc;
      if (w_acc) r_s_acc <= i_in_acc;
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_q;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      // Set takes priority over a coincident clear.
      if (w_push && w_sat) r_sat <= 1'b1;
      else if (i_clr_sat)  r_sat <= 1'b0;
    end
  end

endmodule

// File: tb/tb_acc_quantizer_reader.sv
// Drives a ReLU and a linear instance with identical stimulus and checks both
// against a queue-based reference model of the quantizer and FIFO.
module tb_acc_quantizer_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready, clr_sat;
  logic [20:0] in_acc;

  logic       ir_r, ov_r, sat_r, ir_l, ov_l, sat_l;
  logic [7:0] od_r, od_l;
  logic [2:0] cnt_r, cnt_l;

  int nchk = 0, nerr = 0;

  // reference model state
  int  qr[$], ql[$], gotr[$], gotl[$];
  bit  stg_v;
  int  stg_val;
  bit  msat_r, msat_l;
  bit  last_acc;

  always #5 clk = ~clk;

  acc_quantizer_reader #(.RELU(1)) u_relu (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(ir_r),
    .i_in_acc(in_acc), .o_out_valid(ov_r), .i_out_ready(out_ready),
    .o_out_data(od_r), .o_count(cnt_r), .o_sat_flag(sat_r), .i_clr_sat(clr_sat));

  acc_quantizer_reader #(.RELU(0)) u_lin (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(ir_l),
    .i_in_acc(in_acc), .o_out_valid(ov_l), .i_out_ready(out_ready),
    .o_out_data(od_l), .o_count(cnt_l), .o_sat_flag(sat_l), .i_clr_sat(clr_sat));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic logic [31:0] sx8(input logic [7:0] d);
    return {{24{d[7]}}, d};
  endfunction

  // round-half-up division by 128, then clamp
  function automatic void quant(input int v, input bit relu, output int q, output bit s);
    int t, r;
    t = v + 64;
    r = (t >= 0) ? t / 128 : -((-t + 127) / 128);
    s = 1'b0;
    if (relu && r < 0) q = 0;
    else if (r > 127) begin q = 127; s = 1'b1; end
    else if (r < -128) begin q = -128; s = 1'b1; end
    else q = r;
  endfunction

  // Check current outputs, advance the model across the next edge, then step.
  task automatic tick();
    bit m_ir, pr, pl, sr, sl;
    int q;
    m_ir = (qr.size() + int'(stg_v)) < 4;
    chk("in_ready_r", {31'b0, ir_r}, {31'b0, m_ir});
    chk("in_ready_l", {31'b0, ir_l}, {31'b0, m_ir});
    chk("count_r", {29'b0, cnt_r}, qr.size());
    chk("count_l", {29'b0, cnt_l}, ql.size());
    chk("out_valid_r", {31'b0, ov_r}, {31'b0, qr.size() != 0});
    chk("out_valid_l", {31'b0, ov_l}, {31'b0, ql.size() != 0});
    if (qr.size() != 0) chk("data_r", sx8(od_r), qr[0]);
    if (ql.size() != 0) chk("data_l", sx8(od_l), ql[0]);
    chk("sat_r", {31'b0, sat_r}, {31'b0, msat_r});
    chk("sat_l", {31'b0, sat_l}, {31'b0, msat_l});
    last_acc = in_valid && m_ir;
    pr = (qr.size() != 0) && out_ready;
    pl = (ql.size() != 0) && out_ready;
    if (pr) begin gotr.push_back(int'($signed(od_r))); void'(qr.pop_front()); end
    if (pl) begin gotl.push_back(int'($signed(od_l))); void'(ql.pop_front()); end
    sr = 1'b0; sl = 1'b0;
    if (stg_v) begin
      quant(stg_val, 1'b1, q, sr); qr.push_back(q);
      quant(stg_val, 1'b0, q, sl); ql.push_back(q);
    end
    if (clr_sat) begin msat_r = 1'b0; msat_l = 1'b0; end
    if (sr) msat_r = 1'b1;
    if (sl) msat_l = 1'b1;
    stg_v = last_acc;
    if (last_acc) stg_val = int'($signed(in_acc));
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic send(input int v);
    int n;
    in_valid = 1'b1;
    in_acc = 21'(v);
    n = 0;
    do begin tick(); n++; end while (!last_acc && n < 50);
    chk("send_timeout", {31'b0, last_acc}, 1);
  endtask

  task automatic drain(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic model_reset();
    qr.delete(); ql.delete();
    stg_v = 1'b0; msat_r = 1'b0; msat_l = 1'b0;
  endtask

  initial begin
    int er[$], el[$];
    int sent, cyc, v;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_sat = 1'b0; in_acc = '0;
    model_reset();
    #12;
    chk("rst_in_ready", {31'b0, ir_r}, 1);
    chk("rst_out_valid", {31'b0, ov_l}, 0);
    chk("rst_count", {29'b0, cnt_l}, 0);
    chk("rst_sat", {31'b0, sat_l}, 0);
    chk("rst_data_r", {24'b0, od_r}, 0);
    chk("rst_data_l", {24'b0, od_l}, 0);
    @(negedge clk); rst_n = 1'b1; #1;

    // back-to-back with the consumer always ready
    out_ready = 1'b1;
    gotr.delete(); gotl.delete();
    send(1000); send(63); send(64); send(-300);
    drain(6);
    er = '{8, 0, 1, 0}; el = '{8, 0, 1, -2};
    chk("seq1_len", gotr.size(), 4);
    for (int i = 0; i < 4 && i < gotr.size(); i++) chk("seq1_r", gotr[i], er[i]);
    for (int i = 0; i < 4 && i < gotl.size(); i++) chk("seq1_l", gotl[i], el[i]);

    // rounding, negative and saturating values
    gotr.delete(); gotl.delete();
    send(-300); send(-20000); send(16383);
    drain(6);
    er = '{0, 0, 127}; el = '{-2, -128, 127};
    chk("seq2_len", gotl.size(), 3);
    for (int i = 0; i < 3 && i < gotr.size(); i++) chk("seq2_r", gotr[i], er[i]);
    for (int i = 0; i < 3 && i < gotl.size(); i++) chk("seq2_l", gotl[i], el[i]);
    chk("seq2_sat_l", {31'b0, sat_l}, 1);
    chk("seq2_sat_r", {31'b0, sat_r}, 1);
    clr_sat = 1'b1; tick(); clr_sat = 1'b0;
    chk("clr_sat_l", {31'b0, sat_l}, 0);

    // backpressure: only DEPTH values fit while the consumer stalls
    out_ready = 1'b0;
    gotr.delete(); gotl.delete();
    for (int k = 1; k <= 4; k++) send(128 * k);
    in_acc = 21'(640);
    for (int i = 0; i < 3; i++) tick();
    chk("bp_count", {29'b0, cnt_r}, 4);
    chk("bp_in_ready", {31'b0, ir_l}, 0);
    out_ready = 1'b1;
    send(640);
    drain(8);
    chk("bp_len", gotr.size(), 5);
    for (int i = 0; i < 5 && i < gotr.size(); i++) chk("bp_order_r", gotr[i], i + 1);
    for (int i = 0; i < 5 && i < gotl.size(); i++) chk("bp_order_l", gotl[i], i + 1);

    // saturating write coincides with clear: set wins, then clear alone
    send(-20000);
    in_valid = 1'b0; clr_sat = 1'b1; tick();
    chk("setclr_sat_l", {31'b0, sat_l}, 1);
    tick(); clr_sat = 1'b0;
    chk("clr_after_l", {31'b0, sat_l}, 0);
    drain(4);

    // asynchronous reset with three entries buffered
    out_ready = 1'b0;
    send(500); send(600); send(700);
    drain(1);
    chk("pre_rst_count", {29'b0, cnt_r}, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_count", {29'b0, cnt_r}, 0);
    chk("async_rst_valid", {31'b0, ov_l}, 0);
    model_reset();
    @(negedge clk); rst_n = 1'b1; #1;

    // randomized traffic
    sent = 0; cyc = 0;
    gotr.delete(); gotl.delete();
    while (sent < 200 && cyc < 5000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      clr_sat = ($urandom_range(0, 15) == 0);
      in_valid = ($urandom_range(0, 4) != 0);
      v = int'($signed(21'($urandom))) >>> $urandom_range(0, 12);
      in_acc = 21'(v);
      tick();
      if (last_acc) sent++;
      cyc++;
    end
    chk("rand_sent", sent, 200);
    clr_sat = 1'b0; out_ready = 1'b1;
    drain(8);
    chk("rand_drained", {29'b0, cnt_l}, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
